// File: rtl/rob_pkg.sv
// Shared types and constants for the parametrised reorder buffer.
package rob_pkg;

   // Instruction class carried by each ROB entry
   typedef enum logic [2:0] {
      OP_ALU    = 3'd0,
      OP_LOAD   = 3'd1,
      OP_STORE  = 3'd2,
      OP_BRANCH = 3'd3,
      OP_JALR   = 3'd4
   } op_class_t;

   // Store size encodings presented on cm_st_size
   typedef enum logic [1:0] {
      ST_BYTE = 2'd0,
      ST_HALF = 2'd1,
      ST_WORD = 2'd2
   } st_size_t;

   localparam int unsigned ROB_DEPTH_DFLT = 16;
   localparam int unsigned IO_WIN         = 8;

   // Tag width for a given entry count
   function automatic int unsigned tag_w(input int unsigned depth);
      return $clog2(depth);
   endfunction

   localparam int unsigned TAG_W_DFLT = tag_w(ROB_DEPTH_DFLT);

endpackage

// File: rtl/rob_wb_select.sv
// Priority match of the writeback ports against one tag; lowest port wins.
module rob_wb_select
   import rob_pkg::*;
#(
   parameter int unsigned WB_PORTS = 2,
   parameter int unsigned TAG_W    = 4,
   parameter int unsigned XLEN     = 32
) (
   input  logic [TAG_W-1:0]          tag,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
   input  logic [WB_PORTS*XLEN-1:0]  wb_value,
   input  logic [WB_PORTS*XLEN-1:0]  wb_target,
   output logic                      hit_c,
   output logic [XLEN-1:0]           value_c,
   output logic [XLEN-1:0]           target_c
);

   // Scan from the highest port down so the lowest matching port is left last
   always_comb begin
      hit_c    = 1'b0;
      value_c  = '0;
      target_c = '0;
      for (int k = WB_PORTS - 1; k >= 0; k--) begin
         if (wb_valid[k] && (wb_tag[k*TAG_W +: TAG_W] == tag)) begin
            hit_c    = 1'b1;
            value_c  = wb_value[k*XLEN +: XLEN];
            target_c = wb_target[k*XLEN +: XLEN];
         end
      end
   end

endmodule

// File: rtl/rob_param.sv
// Parametrised reorder buffer: in-order allocate, multi-port writeback,
// single in-order retire with store handshake and branch flush/redirect.
// Optional build macro ROB_BYPASS_EN: operand lookups forward same-cycle
// writebacks; otherwise lookups see registered entry state only.
module rob_param
   import rob_pkg::*;
#(
   parameter int unsigned    DEPTH      = 16,
   parameter int unsigned    XLEN       = 32,
   parameter int unsigned    WB_PORTS   = 2,
   parameter logic [XLEN-1:0] IO_BASE   = 'h30000,
   parameter int unsigned    PRED_IDX_W = 8,
   localparam int unsigned   TAG_W      = tag_w(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      rdy,
   input  logic                      disp_valid,
   output logic                      disp_ready,
   input  logic [2:0]                disp_op,
   input  logic [4:0]                disp_rd,
   input  logic [XLEN-1:0]           disp_pc,
   input  logic                      disp_pred_taken,
   output logic [TAG_W-1:0]          alloc_tag,
   input  logic [2*TAG_W-1:0]        q_tag,
   output logic [1:0]                q_ready,
   output logic [2*XLEN-1:0]         q_value,
   input  logic [WB_PORTS-1:0]       wb_valid,
   input  logic [WB_PORTS*TAG_W-1:0] wb_tag,
   input  logic [WB_PORTS*XLEN-1:0]  wb_value,
   input  logic [WB_PORTS*XLEN-1:0]  wb_target,
   input  logic                      st_addr_valid,
   input  logic [TAG_W-1:0]          st_addr_tag,
   input  logic [XLEN-1:0]           st_addr,
   input  logic                      io_full,
   output logic                      cm_reg_valid,
   output logic [4:0]                cm_rd,
   output logic [XLEN-1:0]           cm_value,
   output logic [TAG_W-1:0]          cm_tag,
   output logic                      cm_st_valid,
   output logic [XLEN-1:0]           cm_st_addr,
   output logic [XLEN-1:0]           cm_st_data,
   output logic [1:0]                cm_st_size,
   input  logic                      cm_st_ack,
   output logic                      bp_upd_valid,
   output logic [PRED_IDX_W-1:0]     bp_upd_idx,
   output logic                      bp_upd_taken,
   output logic                      flush,
   output logic [XLEN-1:0]           redirect_pc,
   output logic [TAG_W-1:0]          head_tag,
   output logic [TAG_W:0]            count,
   output logic                      full,
   output logic                      empty
);

   localparam int unsigned PW = TAG_W + 1;

   // Pointers carry a wrap bit above the entry index
   logic [PW-1:0]    head_q, tail_q, head_n, tail_n;

   // Entry storage
   logic [DEPTH-1:0] ent_ready_q;
   op_class_t        ent_op_q     [DEPTH];
   logic [4:0]       ent_rd_q     [DEPTH];
   logic [XLEN-1:0]  ent_pc_q     [DEPTH];
   logic [DEPTH-1:0] ent_pred_q;
   logic [XLEN-1:0]  ent_value_q  [DEPTH];
   logic [XLEN-1:0]  ent_target_q [DEPTH];
   logic [XLEN-1:0]  ent_addr_q   [DEPTH];

   // Per-entry writeback match
   logic [DEPTH-1:0] upd_hit;
   logic [XLEN-1:0]  upd_value  [DEPTH];
   logic [XLEN-1:0]  upd_target [DEPTH];

   // Retire decisions
   logic [TAG_W-1:0] h_idx, t_idx;
   logic             in_mmio, can_retire, dispatch;
   logic             retire_c, st_start_c, reg_c, bp_c, flush_c;
   logic [XLEN-1:0]  redir_c;

   assign alloc_tag = tail_q[TAG_W-1:0];
   assign head_tag  = head_q[TAG_W-1:0];
   assign h_idx     = head_q[TAG_W-1:0];
   assign t_idx     = tail_q[TAG_W-1:0];

   for (genvar i = 0; i < DEPTH; i++) begin : g_upd
      rob_wb_select #(.WB_PORTS(WB_PORTS), .TAG_W(TAG_W), .XLEN(XLEN)) u_sel (
         .tag      (TAG_W'(i)),
         .wb_valid (wb_valid),
         .wb_tag   (wb_tag),
         .wb_value (wb_value),
         .wb_target(wb_target),
         .hit_c    (upd_hit[i]),
         .value_c  (upd_value[i]),
         .target_c (upd_target[i])
      );
   end

   for (genvar j = 0; j < 2; j++) begin : g_q
      logic [TAG_W-1:0] q_idx;
      assign q_idx = q_tag[j*TAG_W +: TAG_W];
`ifdef ROB_BYPASS_EN
      logic             q_hit;
      logic [XLEN-1:0]  q_wbv;
      logic [XLEN-1:0]  unused_q_target;
      rob_wb_select #(.WB_PORTS(WB_PORTS), .TAG_W(TAG_W), .XLEN(XLEN)) u_sel (
         .tag      (q_idx),
         .wb_valid (wb_valid),
         .wb_tag   (wb_tag),
         .wb_value (wb_value),
         .wb_target(wb_target),
         .hit_c    (q_hit),
         .value_c  (q_wbv),
         .target_c (unused_q_target)
      );
      assign q_ready[j]              = q_hit | ent_ready_q[q_idx];
      assign q_value[j*XLEN +: XLEN] = q_hit ? q_wbv : ent_value_q[q_idx];
`else
      assign q_ready[j]              = ent_ready_q[q_idx];
      assign q_value[j*XLEN +: XLEN] = ent_value_q[q_idx];
`endif
   end

   // Head retire selection and next pointer values
   always_comb begin
      retire_c   = 1'b0;
      st_start_c = 1'b0;
      reg_c      = 1'b0;
      bp_c       = 1'b0;
      flush_c    = 1'b0;
      redir_c    = '0;
      in_mmio    = (ent_addr_q[h_idx] >= IO_BASE) &&
                   ((ent_addr_q[h_idx] - IO_BASE) < XLEN'(IO_WIN));
      can_retire = (head_q != tail_q) && ent_ready_q[h_idx] && !cm_st_valid && !flush;
      dispatch   = disp_valid && disp_ready;

      if (cm_st_valid && cm_st_ack) begin
         retire_c = 1'b1;
      end else if (can_retire) begin
         case (ent_op_q[h_idx])
            OP_ALU, OP_LOAD: begin
               retire_c = 1'b1;
               reg_c    = 1'b1;
            end
            OP_STORE: begin
               if (!(io_full && in_mmio)) st_start_c = 1'b1;
            end
            OP_BRANCH: begin
               retire_c = 1'b1;
               bp_c     = 1'b1;
               if (ent_value_q[h_idx][0] != ent_pred_q[h_idx]) begin
                  flush_c = 1'b1;
                  redir_c = ent_value_q[h_idx][0] ? ent_target_q[h_idx]
                                                  : ent_pc_q[h_idx] + XLEN'(4);
               end
            end
            OP_JALR: begin
               retire_c = 1'b1;
               reg_c    = 1'b1;
               flush_c  = 1'b1;
               redir_c  = ent_target_q[h_idx];
            end
            default: retire_c = 1'b1;
         endcase
      end

      head_n = head_q + PW'(retire_c);
      tail_n = tail_q + PW'(dispatch);
      if (flush) begin
         head_n = head_q;
         tail_n = head_q;
      end
   end

   // Pointers, status, ready bits and registered commit outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         head_q       <= '0;
         tail_q       <= '0;
         count        <= '0;
         full         <= 1'b0;
         empty        <= 1'b1;
         disp_ready   <= 1'b1;
         ent_ready_q  <= '0;
         cm_reg_valid <= 1'b0;
         cm_rd        <= '0;
         cm_value     <= '0;
         cm_tag       <= '0;
         cm_st_valid  <= 1'b0;
         cm_st_addr   <= '0;
         cm_st_data   <= '0;
         cm_st_size   <= '0;
         bp_upd_valid <= 1'b0;
         bp_upd_idx   <= '0;
         bp_upd_taken <= 1'b0;
         flush        <= 1'b0;
         redirect_pc  <= '0;
      end else if (rdy) begin
         head_q     <= head_n;
         tail_q     <= tail_n;
         count      <= tail_n - head_n;
         empty      <= (head_n == tail_n);
         full       <= ((head_n ^ tail_n) == {1'b1, {TAG_W{1'b0}}});
         disp_ready <= ((head_n ^ tail_n) != {1'b1, {TAG_W{1'b0}}}) && !flush_c;

         if (flush) begin
            ent_ready_q <= '0;
         end else begin
            for (int i = 0; i < DEPTH; i++) begin
               if (upd_hit[i]) ent_ready_q[i] <= 1'b1;
            end
            if (dispatch) ent_ready_q[t_idx] <= 1'b0;
         end

         cm_reg_valid <= reg_c;
         if (reg_c) begin
            cm_rd    <= ent_rd_q[h_idx];
            cm_value <= ent_value_q[h_idx];
            cm_tag   <= h_idx;
         end

         bp_upd_valid <= bp_c;
         if (bp_c) begin
            bp_upd_idx   <= ent_pc_q[h_idx][PRED_IDX_W+1:2];
            bp_upd_taken <= ent_value_q[h_idx][0];
         end

         flush <= flush_c;
         if (flush_c) redirect_pc <= redir_c;

         if (st_start_c) begin
            cm_st_valid <= 1'b1;
            cm_st_addr  <= ent_addr_q[h_idx];
            cm_st_data  <= ent_value_q[h_idx];
            // MMIO sink is byte-wide; memory stores retire as full words
            cm_st_size  <= in_mmio ? ST_BYTE : ST_WORD;
         end else if (cm_st_valid && cm_st_ack) begin
            cm_st_valid <= 1'b0;
         end
      end
   end

   // Entry payload capture from dispatch, writeback and store address
   always_ff @(posedge clk) begin
      if (!rst && rdy && !flush) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (upd_hit[i]) begin
               ent_value_q[i]  <= upd_value[i];
               ent_target_q[i] <= upd_target[i];
            end
            if (st_addr_valid && (st_addr_tag == TAG_W'(i))) ent_addr_q[i] <= st_addr;
         end
         if (dispatch) begin
            ent_op_q[t_idx]   <= op_class_t'(disp_op);
            ent_rd_q[t_idx]   <= disp_rd;
            ent_pc_q[t_idx]   <= disp_pc;
            ent_pred_q[t_idx] <= disp_pred_taken;
         end
      end
   end

endmodule

// File: tb/tb_rob_param.sv
// Scoreboard bench for rob_param: stimulus pushes expected commit events,
// a monitor pops and compares whenever the ROB presents one.
module tb_rob_param;
   import rob_pkg::*;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned XLEN  = 32;
   localparam int unsigned WBP   = 2;
   localparam int unsigned TW    = 4;
   localparam int unsigned PIW   = 8;
`ifdef ROB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   typedef logic [127:0] w_t;

   logic clk, rst, rdy;
   logic disp_valid, disp_ready, disp_pred_taken;
   logic [2:0] disp_op;
   logic [4:0] disp_rd;
   logic [XLEN-1:0] disp_pc;
   logic [TW-1:0] alloc_tag;
   logic [2*TW-1:0] q_tag;
   logic [1:0] q_ready;
   logic [2*XLEN-1:0] q_value;
   logic [WBP-1:0] wb_valid;
   logic [WBP*TW-1:0] wb_tag;
   logic [WBP*XLEN-1:0] wb_value, wb_target;
   logic st_addr_valid;
   logic [TW-1:0] st_addr_tag;
   logic [XLEN-1:0] st_addr;
   logic io_full;
   logic cm_reg_valid;
   logic [4:0] cm_rd;
   logic [XLEN-1:0] cm_value;
   logic [TW-1:0] cm_tag;
   logic cm_st_valid;
   logic [XLEN-1:0] cm_st_addr, cm_st_data;
   logic [1:0] cm_st_size;
   logic cm_st_ack;
   logic bp_upd_valid;
   logic [PIW-1:0] bp_upd_idx;
   logic bp_upd_taken;
   logic flush;
   logic [XLEN-1:0] redirect_pc;
   logic [TW-1:0] head_tag;
   logic [TW:0] count;
   logic full, empty;

   int n_cmp = 0;
   int n_err = 0;
   int cyc = 0;
   int tb_tail = 0;
   w_t exp_reg[$];
   w_t exp_st[$];
   w_t exp_bp[$];
   w_t exp_fl[$];
   int reg_cyc[$];

   rob_param #(.DEPTH(DEPTH), .XLEN(XLEN), .WB_PORTS(WBP), .IO_BASE(32'h30000),
               .PRED_IDX_W(PIW)) dut (
      .clk(clk), .rst(rst), .rdy(rdy),
      .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
      .disp_rd(disp_rd), .disp_pc(disp_pc), .disp_pred_taken(disp_pred_taken),
      .alloc_tag(alloc_tag), .q_tag(q_tag), .q_ready(q_ready), .q_value(q_value),
      .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value), .wb_target(wb_target),
      .st_addr_valid(st_addr_valid), .st_addr_tag(st_addr_tag), .st_addr(st_addr),
      .io_full(io_full), .cm_reg_valid(cm_reg_valid), .cm_rd(cm_rd),
      .cm_value(cm_value), .cm_tag(cm_tag), .cm_st_valid(cm_st_valid),
      .cm_st_addr(cm_st_addr), .cm_st_data(cm_st_data), .cm_st_size(cm_st_size),
      .cm_st_ack(cm_st_ack), .bp_upd_valid(bp_upd_valid), .bp_upd_idx(bp_upd_idx),
      .bp_upd_taken(bp_upd_taken), .flush(flush), .redirect_pc(redirect_pc),
      .head_tag(head_tag), .count(count), .full(full), .empty(empty)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input w_t act, input w_t exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name, input w_t act);
      n_cmp++;
      n_err++;
      $display("FAIL %s: got unexpected event %0h, required none", name, act);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr_wb();
      wb_valid = '0; wb_tag = '0; wb_value = '0; wb_target = '0;
      st_addr_valid = 1'b0; st_addr_tag = '0; st_addr = '0;
   endtask

   task automatic set_wb(input int port, input int tag, input logic [31:0] val,
                         input logic [31:0] tgt);
      wb_valid[port] = 1'b1;
      wb_tag[port*TW +: TW] = TW'(tag);
      wb_value[port*XLEN +: XLEN] = val;
      wb_target[port*XLEN +: XLEN] = tgt;
   endtask

   task automatic do_reset();
      rst = 1'b1; disp_valid = 1'b0; cm_st_ack = 1'b0; io_full = 1'b0;
      clr_wb();
      tick(); tick();
      rst = 1'b0;
      tb_tail = 0;
   endtask

   task automatic do_disp(input op_class_t op, input int rd, input logic [31:0] pc,
                          input logic pred);
      int n;
      n = 0;
      disp_valid = 1'b1; disp_op = op; disp_rd = 5'(rd); disp_pc = pc;
      disp_pred_taken = pred;
      while (!disp_ready && n < 40) begin tick(); n++; end
      if (!disp_ready) unexpected("disp_timeout", w_t'(n));
      else chk("alloc_tag", w_t'(alloc_tag), w_t'(tb_tail % DEPTH));
      tick();
      disp_valid = 1'b0;
      tb_tail++;
   endtask

   task automatic wait_flush();
      int n;
      n = 0;
      while (!flush && n < 20) begin tick(); n++; end
      if (!flush) unexpected("flush_timeout", w_t'(n));
   endtask

   // Monitor: pops the matching expectation whenever the ROB emits an event
   initial begin
      logic prev_st;
      w_t e;
      prev_st = 1'b0;
      forever begin
         @(negedge clk);
         if (cm_reg_valid) begin
            if (exp_reg.size() == 0) unexpected("reg_commit", w_t'({cm_rd, cm_value, cm_tag}));
            else begin
               e = exp_reg.pop_front();
               chk("reg_commit", w_t'({cm_rd, cm_value, cm_tag}), e);
               reg_cyc.push_back(cyc);
            end
         end
         if (cm_st_valid && !prev_st) begin
            if (exp_st.size() == 0) unexpected("store_commit", w_t'({cm_st_addr, cm_st_data, cm_st_size}));
            else begin
               e = exp_st.pop_front();
               chk("store_commit", w_t'({cm_st_addr, cm_st_data, cm_st_size}), e);
            end
         end
         if (bp_upd_valid) begin
            if (exp_bp.size() == 0) unexpected("bp_update", w_t'({bp_upd_idx, bp_upd_taken}));
            else begin
               e = exp_bp.pop_front();
               chk("bp_update", w_t'({bp_upd_idx, bp_upd_taken}), e);
            end
         end
         if (flush) begin
            if (exp_fl.size() == 0) unexpected("flush", w_t'(redirect_pc));
            else begin
               e = exp_fl.pop_front();
               chk("flush_redirect", w_t'(redirect_pc), e);
            end
         end
         prev_st = cm_st_valid;
      end
   end

   initial begin
      rdy = 1'b1; q_tag = '0; disp_op = '0; disp_rd = '0; disp_pc = '0;
      disp_pred_taken = 1'b0;
      do_reset();

      // Reset state
      chk("rst_empty", w_t'(empty), 1);
      chk("rst_disp_ready", w_t'(disp_ready), 1);
      chk("rst_count", w_t'(count), 0);
      chk("rst_full", w_t'(full), 0);
      chk("rst_head_tag", w_t'(head_tag), 0);
      chk("rst_cm_st_valid", w_t'(cm_st_valid), 0);

      // Out-of-order writeback, in-order consecutive retire
      reg_cyc.delete();
      exp_reg.push_back(w_t'({5'd1, 32'd7, 4'd0}));
      exp_reg.push_back(w_t'({5'd2, 32'd5, 4'd1}));
      exp_reg.push_back(w_t'({5'd3, 32'd9, 4'd2}));
      do_disp(OP_ALU, 1, 32'h0, 1'b0);
      do_disp(OP_ALU, 2, 32'h4, 1'b0);
      do_disp(OP_ALU, 3, 32'h8, 1'b0);
      set_wb(0, 1, 32'd5, 0); tick(); clr_wb();
      set_wb(0, 0, 32'd7, 0); tick(); clr_wb();
      set_wb(1, 2, 32'd9, 0); tick(); clr_wb();
      repeat (6) tick();
      if (reg_cyc.size() == 3) begin
         chk("retire_gap_0_1", w_t'(reg_cyc[1] - reg_cyc[0]), 1);
         chk("retire_gap_1_2", w_t'(reg_cyc[2] - reg_cyc[1]), 1);
      end else unexpected("retire_count", w_t'(reg_cyc.size()));
      chk("t1_empty", w_t'(empty), 1);

      // Fill to full, retire one while dispatch is held, tag wraps to 0
      do_reset();
      for (int i = 0; i < DEPTH; i++) do_disp(OP_ALU, i + 1, 32'(i * 4), 1'b0);
      chk("full_flag", w_t'(full), 1);
      chk("full_disp_ready", w_t'(disp_ready), 0);
      chk("full_count", w_t'(count), 16);
      exp_reg.push_back(w_t'({5'd1, 32'h100, 4'd0}));
      disp_valid = 1'b1; disp_op = OP_ALU; disp_rd = 5'd20;
      set_wb(0, 0, 32'h100, 0);
      tick(); clr_wb();
      chk("retire_cycle_count", w_t'(count), 16);
      chk("retire_cycle_ready", w_t'(disp_ready), 0);
      tick();
      chk("after_retire_count", w_t'(count), 15);
      chk("after_retire_ready", w_t'(disp_ready), 1);
      chk("wrap_alloc_tag", w_t'(alloc_tag), 0);
      tick();
      disp_valid = 1'b0;
      chk("refill_count", w_t'(count), 16);
      chk("refill_full", w_t'(full), 1);

      // MMIO store stalls on io_full, then commits with handshake
      do_reset();
      io_full = 1'b1;
      do_disp(OP_STORE, 0, 32'h200, 1'b0);
      st_addr_valid = 1'b1; st_addr_tag = 4'd0; st_addr = 32'h30000;
      set_wb(0, 0, 32'hA5, 0);
      tick(); clr_wb();
      for (int i = 0; i < 3; i++) begin
         chk("st_stall_valid", w_t'(cm_st_valid), 0);
         tick();
      end
      exp_st.push_back(w_t'({32'h30000, 32'hA5, 2'd0}));
      io_full = 1'b0;
      tick();
      chk("st_valid_up", w_t'(cm_st_valid), 1);
      tick(); tick();
      cm_st_ack = 1'b1;
      chk("st_head_before_ack", w_t'(head_tag), 0);
      tick();
      cm_st_ack = 1'b0;
      chk("st_valid_dropped", w_t'(cm_st_valid), 0);
      chk("st_head_after_ack", w_t'(head_tag), 1);

      // Just past the MMIO window: io_full does not stall, word size
      io_full = 1'b1;
      exp_st.push_back(w_t'({32'h30008, 32'h5A, 2'd2}));
      do_disp(OP_STORE, 0, 32'h204, 1'b0);
      st_addr_valid = 1'b1; st_addr_tag = 4'd1; st_addr = 32'h30008;
      set_wb(1, 1, 32'h5A, 0);
      tick(); clr_wb();
      begin
         int n;
         n = 0;
         while (!cm_st_valid && n < 10) begin tick(); n++; end
         if (!cm_st_valid) unexpected("st2_timeout", w_t'(n));
      end
      cm_st_ack = 1'b1; tick(); cm_st_ack = 1'b0; io_full = 1'b0;
      chk("st2_head", w_t'(head_tag), 2);

      // Mispredicted branch flushes a ready younger ALU op
      do_reset();
      exp_bp.push_back(w_t'({8'h40, 1'b1}));
      exp_fl.push_back(w_t'(32'h200));
      do_disp(OP_BRANCH, 0, 32'h100, 1'b0);
      do_disp(OP_ALU, 5, 32'h104, 1'b0);
      set_wb(0, 1, 32'h77, 0); tick(); clr_wb();
      set_wb(0, 0, 32'd1, 32'h200); tick(); clr_wb();
      wait_flush();
      chk("flush_disp_ready", w_t'(disp_ready), 0);
      tick();
      chk("post_flush_empty", w_t'(empty), 1);
      chk("post_flush_count", w_t'(count), 0);
      repeat (3) tick();

      // Correctly predicted branch then JALR link commit and redirect
      do_reset();
      exp_bp.push_back(w_t'({8'h41, 1'b1}));
      exp_reg.push_back(w_t'({5'd1, 32'h10C, 4'd1}));
      exp_fl.push_back(w_t'(32'h400));
      do_disp(OP_BRANCH, 0, 32'h104, 1'b1);
      do_disp(OP_JALR, 1, 32'h108, 1'b0);
      set_wb(0, 0, 32'd1, 32'h300);
      set_wb(1, 1, 32'h10C, 32'h400);
      tick(); clr_wb();
      wait_flush();
      tick();
      chk("jalr_empty", w_t'(empty), 1);

      // Two ports to one tag: lowest port wins
      do_reset();
      for (int i = 0; i < 4; i++) do_disp(OP_ALU, i + 1, 32'(i * 4), 1'b0);
      exp_reg.push_back(w_t'({5'd1, 32'h10, 4'd0}));
      exp_reg.push_back(w_t'({5'd2, 32'h11, 4'd1}));
      exp_reg.push_back(w_t'({5'd3, 32'h12, 4'd2}));
      exp_reg.push_back(w_t'({5'd4, 32'hA, 4'd3}));
      set_wb(0, 3, 32'hA, 0);
      set_wb(1, 3, 32'hB, 0);
      tick(); clr_wb();
      q_tag = 8'h03;
      #1;
      chk("dual_port_ready", w_t'(q_ready[0]), 1);
      chk("dual_port_value", w_t'(q_value[31:0]), 32'hA);
      set_wb(0, 0, 32'h10, 0);
      set_wb(1, 1, 32'h11, 0);
      tick(); clr_wb();
      set_wb(0, 2, 32'h12, 0); tick(); clr_wb();

      // Operand lookup in the writeback cycle and the one after
      exp_reg.push_back(w_t'({5'd6, 32'h55, 4'd4}));
      do_disp(OP_ALU, 6, 32'h10, 1'b0);
      do_disp(OP_ALU, 7, 32'h14, 1'b0);
      q_tag = {4'd5, 4'd4};
      set_wb(0, 4, 32'h55, 0);
      #1;
      chk("byp_same_ready", w_t'(q_ready[0]), w_t'(BYP));
      if (BYP) chk("byp_same_value", w_t'(q_value[31:0]), 32'h55);
      chk("lookup_unwritten", w_t'(q_ready[1]), 0);
      tick(); clr_wb();
      #1;
      chk("lookup_next_ready", w_t'(q_ready[0]), 1);
      chk("lookup_next_value", w_t'(q_value[31:0]), 32'h55);
      repeat (8) tick();

      // rdy low freezes dispatch
      chk("pre_freeze_count", w_t'(count), 1);
      rdy = 1'b0;
      disp_valid = 1'b1; disp_op = OP_ALU; disp_rd = 5'd9;
      tick(); tick();
      chk("freeze_count", w_t'(count), 1);
      chk("freeze_alloc_tag", w_t'(alloc_tag), 6);
      rdy = 1'b1; disp_valid = 1'b0;
      tick();
      chk("unfreeze_count", w_t'(count), 1);

      repeat (5) tick();
      chk("reg_queue_drained", w_t'(exp_reg.size()), 0);
      chk("st_queue_drained", w_t'(exp_st.size()), 0);
      chk("bp_queue_drained", w_t'(exp_bp.size()), 0);
      chk("flush_queue_drained", w_t'(exp_fl.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/rob_param.md
Name: rob_param

Overview:
- Parametrised reorder buffer for the out-of-order RV32I core; sits between decoder/dispatch, the execution units (ALU, LSB) and the register file / predictor.
- Allocates tags in program order and collects results from WB_PORTS writeback ports.
- Retires one instruction per cycle at the head: register commit, store commit handshake, or branch resolution with flush/redirect.

Parameters:
- DEPTH, 16, entry count; power of two, at least 4.
- XLEN, 32, data and address width.
- WB_PORTS, 2, number of independent writeback ports.
- IO_BASE, 32'h30000, first MMIO address; the MMIO window is IO_BASE..IO_BASE+7.
- PRED_IDX_W, 8, width of the predictor index (pc[PRED_IDX_W+1:2]).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- rdy  in  1  global enable; low freezes all state
- disp_valid  in  1  dispatch request
- disp_ready  out  1  equals !full && !flush
- disp_op  in  3  op class (rob_pkg op_class_t)
- disp_rd  in  5  destination register
- disp_pc  in  XLEN  instruction pc
- disp_pred_taken  in  1  predictor guess
- alloc_tag  out  TAG_W  tag given to the current dispatch (tail)
- q_tag[2]  in  2*TAG_W  operand lookup tags
- q_ready[2]  out  2  entry ready
- q_value[2]  out  2*XLEN  entry value
- wb_valid  in  WB_PORTS  writeback strobes
- wb_tag  in  WB_PORTS*TAG_W
- wb_value  in  WB_PORTS*XLEN  result, store data, or branch taken bit in [0]
- wb_target  in  WB_PORTS*XLEN  branch/JALR target
- st_addr_valid  in  1  store address update
- st_addr_tag  in  TAG_W
- st_addr  in  XLEN
- io_full  in  1  MMIO output buffer full
- cm_reg_valid  out  1  one-cycle register commit pulse
- cm_rd  out  5
- cm_value  out  XLEN
- cm_tag  out  TAG_W
- cm_st_valid  out  1  store commit request, held until ack
- cm_st_addr  out  XLEN
- cm_st_data  out  XLEN
- cm_st_size  out  2  0=byte, 1=half, 2=word
- cm_st_ack  in  1  store performed
- bp_upd_valid  out  1  predictor update pulse
- bp_upd_idx  out  PRED_IDX_W
- bp_upd_taken  out  1
- flush  out  1  one-cycle mispredict pulse
- redirect_pc  out  XLEN
- head_tag  out  TAG_W
- count  out  TAG_W+1
- full  out  1
- empty  out  1

Behaviour:
- Reset rst: synchronous, active-high; clock clk. Reset clears pointers, count and all ready bits. Every output resets to 0 except disp_ready (1) and empty (1).
- rdy=0: no state changes; outputs hold.
- Pointers are TAG_W+1 bits wide with a wrap bit.
  - empty = pointers equal.
  - full = pointers equal except the MSB.
  - count = tail - head, modulo 2^(TAG_W+1).
- Dispatch fires when disp_valid && disp_ready. The tail entry is written with ready=0; tail increments.
- Writeback: wb_valid[k] sets value, target and ready=1 for tag wb_tag[k].
  - If several ports hit the same tag in one cycle, the lowest k wins.
  - Store entries become ready when their data writeback arrives. The address comes separately via st_addr_valid.
- Operand lookup is combinational from entry state (see the optional feature).
- Commit considers the head only when !empty && head ready && !cm_st_valid, at most one retire per cycle:
  - ALU/LOAD: pulse cm_reg_valid with rd, value and tag. The head advances in the same cycle.
  - STORE: if io_full && st_addr falls in the MMIO window, stall. Otherwise raise cm_st_valid and hold it until cm_st_ack. On ack, drop cm_st_valid and advance the head the same cycle.
  - BRANCH: pulse bp_upd_valid with taken=value[0]. If taken != pred_taken, pulse flush with redirect_pc = taken ? target : pc+4.
  - JALR: register commit (link value), and unconditionally flush with redirect_pc = target.
- Flush: in the cycle after the flush pulse, the ROB is empty and all ready bits are clear.
  - Dispatch and writebacks in the flush cycle are ignored.
  - An in-flight cm_st_valid is never flushed, because stores commit only at the head.
- Simultaneous dispatch and retire leaves count unchanged. Full and retire in the same cycle: dispatch is still refused that cycle (disp_ready is registered-state based).
- Pointers wrap modulo DEPTH.

Optional Feature:
- ROB_BYPASS_EN defined: q_ready/q_value forward same-cycle wb_* hits (lowest port wins), so a lookup sees a result in the cycle it is written back.
- Undefined: lookups see registered entry state only, giving one cycle of extra latency.

Decomposition:
- rob_pkg holds:
  - op_class_t (OP_ALU, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR)
  - store size encodings
  - TAG_W = $clog2(DEPTH)
  - IO window width constant
- One sub-module, rob_wb_select: a priority match of WB_PORTS writebacks against a given tag, returning hit, value and target. It is instanced per lookup port and reused for entry update.

Test Plan:
- Reset, then dispatch 3 ALU ops (tags 0,1,2); writeback tag1=5, tag0=7, tag2=9 → cm_reg_valid pulses in order with values 7, 5, 9 on consecutive cycles.
- Dispatch DEPTH ops → full=1, disp_ready=0, count=16. Retire one while disp_valid is held → next cycle count=15, then dispatch accepted with tag 0 (wrap).
- Store to 0x30000 at head with io_full=1 → no cm_st_valid. Drop io_full → cm_st_valid=1 with size 0; ack after 3 cycles → head advances on the ack cycle.
- Branch pc=0x100, pred_taken=0, wb value=1, target=0x200 → bp_upd_valid, flush=1, redirect_pc=0x200; next cycle empty=1.
- Ports 0 and 1 both write tag 3 (values 0xA, 0xB) → entry 3 holds 0xA.
- With ROB_BYPASS_EN: q_tag0=4 and wb tag 4 value 0x55 in the same cycle → q_ready0=1, q_value0=0x55. Without it → q_ready0=0 that cycle, 1 the next.
